logic_function_tester: RTL and testbench
========================================

LOGIC_FUNCTION_TESTER -- requirements
Module: logic_function_tester

Interface
REQ-001 Parameter SETTLE_CYCLES, default 2, range 0..15: wait cycles between driving a vector and sampling the DUT outputs.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 reset_n  input  1  asynchronous, active-low reset.
REQ-004 start  input  1  request to run a full sweep; sampled only in IDLE or DONE.
REQ-005 A, B, C  output  1 each  stimulus driven to the logic_functions DUT.
REQ-006 O1, O2  input  1 each  DUT responses under test.
REQ-007 busy  output  1  high while a sweep is in progress.
REQ-008 done  output  1  high while in DONE.
REQ-009 pass  output  1  high in DONE when err_count == 0.
REQ-010 err_count  output  4  number of mismatching vectors in the last sweep.
REQ-011 fail_valid  output  1  at least one mismatch captured this sweep.
REQ-012 first_fail  output  3  {A,B,C} of the first mismatching vector.

Function
REQ-013 The block SHALL compute the expected outputs internally as O1 = AC + A'B and O2 = (A+C')(BC), which reduces to ABC.
REQ-014 Expected {O1,O2} by vector {A,B,C} SHALL be: 000:00, 001:00, 010:10, 011:10, 100:00, 101:10, 110:00, 111:11.
REQ-015 The FSM SHALL have exactly these states: IDLE, DRIVE, SETTLE, CHECK, DONE.
REQ-016 IDLE/DONE with start=1 SHALL transition to DRIVE with vec=0 and clear err_count, fail_valid and first_fail; IDLE/DONE with start=0 SHALL hold state.
REQ-017 DRIVE SHALL last 1 cycle, with {A,B,C} registered to vec, then go to SETTLE, or directly to CHECK when SETTLE_CYCLES=0.
REQ-018 SETTLE SHALL last exactly SETTLE_CYCLES cycles, counted by an internal 4-bit counter, then go to CHECK.
REQ-019 CHECK SHALL last 1 cycle, comparing the sampled {O1,O2} with the expected value for vec.
- On mismatch: err_count increments.
- On the first mismatch: fail_valid is set and first_fail is loaded with vec.
REQ-020 From CHECK, the FSM SHALL go to DONE when vec==7; otherwise vec increments and the FSM goes to DRIVE.
REQ-021 Per-vector time SHALL be SETTLE_CYCLES+2 cycles; done SHALL rise 8*(SETTLE_CYCLES+2) clock edges after the edge that samples start.
REQ-022 {A,B,C} SHALL hold the current vec through DRIVE, SETTLE and CHECK, and SHALL be 000 in IDLE and DONE.
REQ-023 busy SHALL be 1 exactly in DRIVE, SETTLE and CHECK; done SHALL be 1 exactly in DONE.
REQ-024 start asserted while busy SHALL be ignored, with no restart and no effect on results.
REQ-025 err_count, fail_valid and first_fail SHALL hold their values in DONE until the next accepted start.
REQ-026 err_count SHALL not overflow, because its maximum is 8 in 4 bits.
REQ-027 The unknown-free comparison SHALL treat O1/O2 as plain 1-bit values; no X handling is required.
REQ-028 All outputs SHALL be registered; none SHALL depend combinationally on O1, O2 or start.

Reset
REQ-029 reset_n=0 SHALL, asynchronously and at any time including mid-sweep, force state to IDLE and set vec, the settle counter, A, B, C, busy, done, pass, err_count, fail_valid and first_fail to 0.
REQ-030 After reset_n deasserts, the block SHALL remain in IDLE until start is sampled high.

Verification
REQ-031 Correct DUT model, SETTLE_CYCLES=2, start pulse -> done rises 32 edges later; pass=1, err_count=0, fail_valid=0; A/B/C step through 000..111.
REQ-032 O1 stuck at 0 -> err_count=4 (vectors 010, 011, 101, 111); first_fail=010; fail_valid=1; pass=0.
REQ-033 O2 inverted -> err_count=8, first_fail=000, pass=0.
REQ-034 start re-pulsed while busy at vector 3 -> ignored, and done timing is unchanged; start pulsed in DONE -> results cleared and new sweep runs.
REQ-035 reset_n low for 1 cycle while vec=5 -> all outputs 0 immediately, state IDLE; subsequent start completes a normal sweep.
REQ-036 SETTLE_CYCLES=0, correct DUT -> done 16 edges after start; pass=1.

Source files
------------

// File: rtl/logic_function_tester.sv
// logic_function_tester: exhaustive 3-input sweep tester for the logic_functions
// block. It drives every {A,B,C} vector, waits SETTLE_CYCLES, then compares the
// returned {O1,O2} against an internal golden model and records the results.
//
// Ports
//   clk         single clock, rising edge
//   reset_n     asynchronous active-low reset
//   start       run a sweep (accepted only in IDLE or DONE)
//   A, B, C     stimulus to the block under test (registered)
//   O1, O2      responses from the block under test
//   busy        sweep in progress (DRIVE / SETTLE / CHECK)
//   done        sweep finished, results valid
//   pass        done with no mismatches
//   err_count   number of mismatching vectors in the last sweep
//   fail_valid  at least one mismatch captured this sweep
//   first_fail  {A,B,C} of the first mismatching vector
module logic_function_tester #(
  parameter int unsigned SETTLE_CYCLES = 2
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       start,
  output logic       A,
  output logic       B,
  output logic       C,
  input  logic       O1,
  input  logic       O2,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [3:0] err_count,
  output logic       fail_valid,
  output logic [2:0] first_fail
);

  localparam int unsigned VEC_W = 3;
  localparam int unsigned CNT_W = 4;
  localparam int unsigned ERR_W = 4;

  // Last count value of SETTLE; unused when SETTLE is skipped entirely.
  localparam logic [CNT_W-1:0] SETTLE_LAST =
    CNT_W'((SETTLE_CYCLES == 0) ? 0 : SETTLE_CYCLES - 1);
  localparam logic [VEC_W-1:0] VEC_LAST = '1;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    DRIVE  = 3'd1,
    SETTLE = 3'd2,
    CHECK  = 3'd3,
    DONE   = 3'd4
  } state_t;

  state_t             state;
  state_t             state_next;
  logic [VEC_W-1:0]   vec;
  logic [CNT_W-1:0]   cnt;

  logic [VEC_W-1:0]   vec_d;
  logic [CNT_W-1:0]   cnt_d;
  logic [ERR_W-1:0]   err_d;
  logic               fv_d;
  logic [VEC_W-1:0]   ff_d;
  logic               busy_d;
  logic               done_d;
  logic               pass_d;
  logic [VEC_W-1:0]   abc_d;

  logic               exp_o1;
  logic               exp_o2;
  logic               mismatch;

  // Golden model with vec = {A,B,C}: O1 = AC + A'B, O2 = (A+C')(BC) = ABC.
  assign exp_o1   = (vec[2] & vec[0]) | (~vec[2] & vec[1]);
  assign exp_o2   = &vec;
  assign mismatch = ({O1, O2} != {exp_o1, exp_o2});

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic.
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE, DONE: if (start) state_next = DRIVE;
      DRIVE:      state_next = (SETTLE_CYCLES == 0) ? CHECK : SETTLE;
      SETTLE:     if (cnt == SETTLE_LAST) state_next = CHECK;
      CHECK:      state_next = (vec == VEC_LAST) ? DONE : DRIVE;
      default:    state_next = IDLE;
    endcase
  end

  // Next values for the datapath and for every registered output. Outputs are
  // derived from state_next so they line up with the state they describe.
  always_comb begin
    vec_d = vec;
    cnt_d = cnt;
    err_d = err_count;
    fv_d  = fail_valid;
    ff_d  = first_fail;
    unique case (state)
      IDLE, DONE: begin
        if (start) begin
          vec_d = '0;
          cnt_d = '0;
          err_d = '0;
          fv_d  = 1'b0;
          ff_d  = '0;
        end
      end
      DRIVE:  cnt_d = '0;
      SETTLE: cnt_d = cnt + CNT_W'(1);
      CHECK: begin
        if (mismatch) begin
          // At most 8 mismatches per sweep, so 4 bits never wrap.
          err_d = err_count + ERR_W'(1);
          if (!fail_valid) begin
            fv_d = 1'b1;
            ff_d = vec;
          end
        end
        if (vec != VEC_LAST) vec_d = vec + VEC_W'(1);
      end
      default: ;
    endcase
    busy_d = (state_next == DRIVE) || (state_next == SETTLE) || (state_next == CHECK);
    done_d = (state_next == DONE);
    pass_d = done_d && (err_d == '0);
    abc_d  = busy_d ? vec_d : '0;
  end

  // Datapath and output registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vec        <= '0;
      cnt        <= '0;
      err_count  <= '0;
      fail_valid <= 1'b0;
      first_fail <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      pass       <= 1'b0;
      A          <= 1'b0;
      B          <= 1'b0;
      C          <= 1'b0;
    end else begin
      vec        <= vec_d;
      cnt        <= cnt_d;
      err_count  <= err_d;
      fail_valid <= fv_d;
      first_fail <= ff_d;
      busy       <= busy_d;
      done       <= done_d;
      pass       <= pass_d;
      {A, B, C}  <= abc_d;
    end
  end

endmodule

// File: tb/tb_logic_function_tester.sv
// Directed bench for logic_function_tester: one instance with SETTLE_CYCLES=2
// and one with SETTLE_CYCLES=0, each fed by a behavioural logic_functions model
// with selectable faults (0 = correct, 1 = O1 stuck at 0, 2 = O2 inverted).
module tb_logic_function_tester;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       start2;
  logic       start0;
  logic       sel;
  logic [1:0] fault;

  logic       a2, b2, c2, o1_2, o2_2, busy2, done2, pass2, fv2;
  logic [3:0] err2;
  logic [2:0] ff2;
  logic       a0, b0, c0, o1_0, o2_0, busy0, done0, pass0, fv0;
  logic [3:0] err0;
  logic [2:0] ff0;

  logic [2:0] m_abc;
  logic       m_busy, m_done, m_pass, m_fv;
  logic [3:0] m_err;
  logic [2:0] m_ff;

  int checks   = 0;
  int failures = 0;
  int edges;

  always #5 clk = ~clk;

  function automatic logic [1:0] model(input logic a, input logic b, input logic c,
                                       input logic [1:0] f);
    logic o1;
    logic o2;
    o1 = (a & c) | (~a & b);
    o2 = a & b & c;
    if (f == 2'd1) o1 = 1'b0;
    if (f == 2'd2) o2 = ~o2;
    return {o1, o2};
  endfunction

  assign {o1_2, o2_2} = model(a2, b2, c2, fault);
  assign {o1_0, o2_0} = model(a0, b0, c0, fault);

  assign m_abc  = sel ? {a0, b0, c0} : {a2, b2, c2};
  assign m_busy = sel ? busy0 : busy2;
  assign m_done = sel ? done0 : done2;
  assign m_pass = sel ? pass0 : pass2;
  assign m_fv   = sel ? fv0   : fv2;
  assign m_err  = sel ? err0  : err2;
  assign m_ff   = sel ? ff0   : ff2;

  logic_function_tester #(.SETTLE_CYCLES(2)) dut2 (
    .clk(clk), .reset_n(reset_n), .start(start2),
    .A(a2), .B(b2), .C(c2), .O1(o1_2), .O2(o2_2),
    .busy(busy2), .done(done2), .pass(pass2),
    .err_count(err2), .fail_valid(fv2), .first_fail(ff2)
  );

  logic_function_tester #(.SETTLE_CYCLES(0)) dut0 (
    .clk(clk), .reset_n(reset_n), .start(start0),
    .A(a0), .B(b0), .C(c0), .O1(o1_0), .O2(o2_0),
    .busy(busy0), .done(done0), .pass(pass0),
    .err_count(err0), .fail_valid(fv0), .first_fail(ff0)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic set_start(input logic v);
    if (sel) start0 = v; else start2 = v;
  endtask

  // Pulse start, then count edges after the sampling edge until done rises.
  task automatic sweep(input int per, input int pulse_at, input bit chk_abc,
                       output int n_edges);
    n_edges = -1;
    @(negedge clk);
    set_start(1'b1);
    @(posedge clk); #1;
    set_start(1'b0);
    if (chk_abc) begin
      check("busy_in_drive", 32'(m_busy), 32'd1);
      check("abc_vec0", 32'(m_abc), 32'd0);
    end
    for (int n = 1; n <= 200; n++) begin
      @(posedge clk); #1;
      if (n == pulse_at)     set_start(1'b1);
      if (n == pulse_at + 1) set_start(1'b0);
      if (chk_abc && (n % per == 0) && (n < 8 * per))
        check($sformatf("abc_vec%0d", n / per), 32'(m_abc), 32'(n / per));
      if (m_done) begin
        n_edges = n;
        break;
      end
    end
  endtask

  task automatic check_results(input string tag, input int n_edges, input int exp_edges,
                               input int exp_err, input int exp_fv, input int exp_ff,
                               input int exp_pass);
    check({tag, "_edges"}, 32'(n_edges), 32'(exp_edges));
    check({tag, "_done"},  32'(m_done),  32'd1);
    check({tag, "_busy"},  32'(m_busy),  32'd0);
    check({tag, "_abc"},   32'(m_abc),   32'd0);
    check({tag, "_err"},   32'(m_err),   32'(exp_err));
    check({tag, "_fv"},    32'(m_fv),    32'(exp_fv));
    check({tag, "_ff"},    32'(m_ff),    32'(exp_ff));
    check({tag, "_pass"},  32'(m_pass),  32'(exp_pass));
  endtask

  initial begin
    reset_n = 1'b1;
    start2  = 1'b0;
    start0  = 1'b0;
    sel     = 1'b0;
    fault   = 2'd0;

    // Reset values.
    #2 reset_n = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_abc",   32'(m_abc),  32'd0);
    check("rst_busy",  32'(m_busy), 32'd0);
    check("rst_done",  32'(m_done), 32'd0);
    check("rst_pass",  32'(m_pass), 32'd0);
    check("rst_err",   32'(m_err),  32'd0);
    check("rst_fv",    32'(m_fv),   32'd0);
    check("rst_ff",    32'(m_ff),   32'd0);
    check("rst_busy0", 32'(busy0),  32'd0);
    reset_n = 1'b1;

    // Stays idle without start.
    repeat (3) @(negedge clk);
    check("idle_busy", 32'(m_busy), 32'd0);
    check("idle_done", 32'(m_done), 32'd0);

    // Correct model, SETTLE_CYCLES=2.
    sweep(4, -1, 1'b1, edges);
    check_results("good", edges, 32, 0, 0, 0, 1);
    repeat (3) @(negedge clk);
    check("good_hold_done", 32'(m_done), 32'd1);
    check("good_hold_pass", 32'(m_pass), 32'd1);

    // O1 stuck at 0: mismatches at 010, 011, 101, 111.
    fault = 2'd1;
    sweep(4, -1, 1'b0, edges);
    check_results("o1_stuck", edges, 32, 4, 1, 2, 0);
    repeat (3) @(negedge clk);
    check("o1_stuck_hold_err", 32'(m_err), 32'd4);
    check("o1_stuck_hold_ff",  32'(m_ff),  32'd2);

    // O2 inverted: every vector mismatches.
    fault = 2'd2;
    sweep(4, -1, 1'b0, edges);
    check_results("o2_inv", edges, 32, 8, 1, 0, 0);

    // Start re-pulsed during vector 3 is ignored; restart from DONE clears results.
    fault = 2'd0;
    sweep(4, 13, 1'b0, edges);
    check_results("restart", edges, 32, 0, 0, 0, 1);

    // Reset mid-sweep at vector 5.
    fault = 2'd1;
    @(negedge clk);
    start2 = 1'b1;
    @(posedge clk); #1;
    start2 = 1'b0;
    repeat (21) @(posedge clk);
    #1;
    check("pre_rst_abc", 32'(m_abc), 32'd5);
    check("pre_rst_err", 32'(m_err), 32'd2);
    reset_n = 1'b0;
    #1;
    check("mid_rst_abc",  32'(m_abc),  32'd0);
    check("mid_rst_busy", 32'(m_busy), 32'd0);
    check("mid_rst_done", 32'(m_done), 32'd0);
    check("mid_rst_err",  32'(m_err),  32'd0);
    check("mid_rst_fv",   32'(m_fv),   32'd0);
    check("mid_rst_ff",   32'(m_ff),   32'd0);
    check("mid_rst_pass", 32'(m_pass), 32'd0);
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (4) @(negedge clk);
    check("post_rst_busy", 32'(m_busy), 32'd0);
    check("post_rst_done", 32'(m_done), 32'd0);

    // Normal sweep after reset.
    fault = 2'd0;
    sweep(4, -1, 1'b0, edges);
    check_results("post_rst", edges, 32, 0, 0, 0, 1);

    // SETTLE_CYCLES=0 instance.
    sel = 1'b1;
    sweep(2, -1, 1'b1, edges);
    check_results("settle0", edges, 16, 0, 0, 0, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
